seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the watch's common-anode 7-segment display. It shares one combinational hex-to-7-segment decoder across NUM_DIGITS digits. Each scan cycle it sends one nibble to the decoder, registers the returned pattern, and drives a single anode with brightness PWM and an anti-ghost guard interval. New display values are accepted over a valid/ready handshake and applied only at frame boundaries, so the display never shows a mix of old and new digits.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
SLOT_CYCLES, 50000, clocks per digit ON slot; must be a multiple of 16
GUARD_CYCLES, 500, clocks with all anodes off before each digit slot (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  new display value offered
load_ready  out  1  controller can accept load_data
load_data  in  4*NUM_DIGITS  hex digits; digit i = bits [4i+3:4i], digit 0 = rightmost
blank_mask  in  NUM_DIGITS  1 = force digit i blank (live, not latched)
dp_mask  in  NUM_DIGITS  1 = light decimal point of digit i (live)
lz_suppress  in  1  1 = blank leading zero digits
brightness  in  4  PWM level 0..15; 0 = dark
nibble_out  out  4  nibble sent to the decoder
seg_in  in  7  active-low pattern returned by the decoder (combinational)
seg_out  out  7  active-low segments to the pads
dp_out  out  1  active-low decimal point
an_out  out  NUM_DIGITS  active-low anode enables

Behaviour:
- Reset (async assert, sync release): state GUARD, digit index 0, counters 0, display register 0, pending empty, load_ready=1, an_out all 1, seg_out=7'h7F, dp_out=1.
- FSM states:
  - GUARD: all anodes off, runs GUARD_CYCLES, then goes to ON.
  - ON: runs SLOT_CYCLES. When ON ends, digit index = (index+1) mod NUM_DIGITS, then back to GUARD.
  - Frame = NUM_DIGITS*(GUARD_CYCLES+SLOT_CYCLES) clocks.
- nibble_out = display register digit[index]. It is combinational from registered state and stable for the whole slot.
- seg_out, dp_out and an_out are registered together, so the decoder adds one cycle of latency. Anodes and segments change on the same edge.
- Digit is blank (seg_out=7'h7F, dp_out=1) when either:
  - blank_mask[index]=1; or
  - lz_suppress=1, index!=0, and every digit from NUM_DIGITS-1 down to index is 0.
- Digit 0 is never zero-suppressed. Any non-blank digit outputs seg_out=seg_in and dp_out=~dp_mask[index].
- PWM in ON:
  - phase = slot_counter / (SLOT_CYCLES/16), range 0..15.
  - an_out[index]=0 only while phase < brightness; all other anodes are always 1.
  - brightness=0 keeps all anodes off; 15 gives 15/16 duty.
  - brightness is sampled live.
- Handshake:
  - Transfer occurs when load_valid & load_ready at a rising edge; load_data goes into the pending register and load_ready drops to 0 on the next cycle.
  - Frame boundary = last ON cycle of digit NUM_DIGITS-1. At that edge, if pending is full: display register <= pending, pending cleared, load_ready=1 from the next cycle.
  - A transfer on a boundary edge while pending is empty fills pending and is applied at the next boundary, not the current one.
  - With pending full, load_ready=0, so no overwrite is possible.
  - Only the newest accepted value is displayed; no queueing beyond one entry.
- Reset mid-frame: outputs blank immediately (async), and a pending value is discarded.
- Counters are sized to clog2 of their terminal values and wrap only via the FSM.

Test Plan:
Use NUM_DIGITS=4, SLOT_CYCLES=32, GUARD_CYCLES=2 for all scenarios.
1. Reset then load 16'h1234, brightness=15 -> load_ready drops 1 cycle after the transfer. From the next frame, digit0 shows an_out=4'b1110 with nibble_out=4, seg_out=7'b0011001. Then digit1 with nibble 3 (7'b0110000), digit2 with 2, digit3 with 1. Each anode is low for 30 of 32 ON cycles and all anodes are 1 during the 2 guard cycles.
2. Load 16'h00A0, lz_suppress=1 -> digits 3 and 2 give seg_out=7'h7F, digit1 gives 7'b0001000, digit0 gives 7'b1000000. Load 16'h0000 -> only digit0 lit, showing 0.
3. Mid-frame load of 16'hFFFF, then a second load_valid with 16'h8888 -> the second value is held off (load_ready=0) until the boundary. No frame mixes old and new digits; 8888 appears one frame after FFFF.
4. brightness=0 -> an_out stays 4'b1111 for a whole frame. brightness=8 -> each anode is low for exactly 16 cycles per slot.
5. blank_mask=4'b0100, dp_mask=4'b0010 -> digit2 blank with dp_out=1; digit1 has dp_out=0; others have dp_out=1.
6. Assert rst_n=0 during the ON slot of digit2 with a pending value -> an_out=4'b1111 and seg_out=7'h7F immediately. After release: display=0, load_ready=1, scan restarts at the digit0 guard.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with a shared external
// hex decoder, brightness PWM, anti-ghost guard interval and frame-aligned display updates.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_suppress,
    input  logic [3:0]              brightness,
    output logic [3:0]              nibble_out,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out
);

    localparam int CMAX = (SLOT_CYCLES > GUARD_CYCLES) ? SLOT_CYCLES : GUARD_CYCLES;
    localparam int CW   = $clog2(CMAX);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int PH   = SLOT_CYCLES / 16;
    localparam int DW   = 4 * NUM_DIGITS;

    typedef enum logic {
        GUARD,
        ON
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  full_q, full_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  last_guard, last_on, boundary, blank;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [CW+3:0]         thr;

    assign load_ready = ~full_q;
    assign nibble_out = disp_q[{idx_q, 2'b00} +: 4];
    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;

    // upper_zero[i]: digits NUM_DIGITS-1 down to i are all zero
    always_comb begin
        upper_zero = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            upper_zero[i] = ((disp_q >> (4 * i)) == '0);
        end
    end

    assign last_guard = (state_q == GUARD) && (cnt_q == CW'(GUARD_CYCLES - 1));
    assign last_on    = (state_q == ON) && (cnt_q == CW'(SLOT_CYCLES - 1));
    assign boundary   = last_on && (idx_q == IW'(NUM_DIGITS - 1));
    assign blank      = blank_mask[idx_q] | (lz_suppress & (idx_q != '0) & upper_zero[idx_q]);
    // phase < brightness  <=>  slot counter < brightness * (SLOT_CYCLES/16)
    assign thr        = (CW + 4)'(brightness) * (CW + 4)'(PH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        disp_d  = disp_q;
        pend_d  = pend_q;
        full_d  = full_q;
        an_d    = '1;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;

        case (state_q)
            GUARD: begin
                if (last_guard) begin
                    state_d = ON;
                    cnt_d   = '0;
                end
            end
            ON: begin
                if ({4'b0000, cnt_q} < thr) begin
                    an_d[idx_q] = 1'b0;
                end
                if (!blank) begin
                    seg_d = seg_in;
                    dp_d  = ~dp_mask[idx_q];
                end
                if (last_on) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
                end
            end
            default: state_d = GUARD;
        endcase

        // apply and accept are exclusive: accept needs pending empty, apply needs it full
        if (boundary && full_q) begin
            disp_d = pend_q;
            full_d = 1'b0;
        end else if (load_valid && !full_q) begin
            pend_d = load_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GUARD;
            cnt_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
            full_q  <= 1'b0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            full_q  <= full_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

endmodule
